// File: rtl/apb_pwm_multi_if.sv
// APB3 slave-side bus bundle for apb_pwm_multi.
// Carries the select/enable/write controls, address, write and read data,
// and the ready/error responses.
interface apb_pwm_multi_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_pwm_multi.sv
// apb_pwm_multi: APB3 slave with NCH PWM channels that share one period
// counter, plus an H-bridge gate driver with dead-time insertion.
// PERIOD/DUTY writes land in shadow registers and reach the counter logic
// only at a wrap (or continuously while disabled), so outputs never glitch.
// Optional feature: define PWM_CENTER_ALIGN_EN to enable CTRL.CENTER
// (up/down counting). Without it CTRL[2] is not stored and reads 0.
module apb_pwm_multi #(
  parameter int NCH            = 2,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 40000,
  parameter int DEFAULT_DUTY   = 20000,
  parameter int DT_W           = 8
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_pwm_multi_if.slave      apb,
  output logic                FABINT,
  output logic [NCH-1:0]      PWM,
  output logic [3:0]          H_IN
);

  typedef enum logic {ST_IDLE, ST_DEAD} hb_state_e;

  localparam logic [CNT_W-1:0] DEF_P  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D  = CNT_W'(DEFAULT_DUTY);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [DT_W-1:0]  DT_ONE = DT_W'(1);

  logic                en_q, en_d, irq_en_q, irq_en_d, wrap_q, wrap_d;
  logic [CNT_W-1:0]    period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    duty_sh_q [NCH];
  logic [CNT_W-1:0]    duty_sh_d [NCH];
  logic [CNT_W-1:0]    duty_act_q [NCH];
  logic [CNT_W-1:0]    duty_act_d [NCH];
  logic [DT_W-1:0]     deadtime_q, deadtime_d, dt_q, dt_d, dt_load;
  logic [NCH-1:0]      pwm_q, pwm_d;
  hb_state_e           state_q, state_d;
  logic [3:0]          h_act_q, h_act_d, h_tgt_q, h_tgt_d, h_in_q, h_in_d;
`ifdef PWM_CENTER_ALIGN_EN
  logic                center_q, center_d, center_act_q, center_act_d, down_q, down_d;
`endif

  logic        acc, wr_en, duty_hit, mapped, hb_illegal, hb_wr, wrap_now, load;
  logic [5:0]  word, duty_idx;
  logic [31:0] rdata;
  logic        unused_bits;

  assign word        = apb.PADDR[7:2];
  assign acc         = apb.PSEL & apb.PENABLE;
  assign wr_en       = acc & apb.PWRITE;
  assign duty_hit    = (word >= 6'd8) && (word < 6'(8 + NCH));
  assign duty_idx    = word - 6'd8;
  assign mapped      = (word <= 6'd4) || duty_hit;
  assign hb_illegal  = (apb.PWDATA[1] & apb.PWDATA[0]) | (apb.PWDATA[3] & apb.PWDATA[2]);
  assign hb_wr       = wr_en && (word == 6'd4) && !hb_illegal;
  assign apb.PSLVERR = acc & (!mapped | (apb.PWRITE & (word == 6'd4) & hb_illegal));
  assign apb.PREADY  = 1'b1;
  assign apb.PRDATA  = rdata;
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  assign FABINT = irq_en_q & wrap_q;
  assign PWM    = pwm_q;
  assign H_IN   = h_in_q;

  // Read mux: shadow values for PERIOD/DUTY, zero for unmapped words
  always_comb begin
    rdata = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (word)
        6'd0: begin
          rdata[1:0] = {irq_en_q, en_q};
`ifdef PWM_CENTER_ALIGN_EN
          rdata[2] = center_q;
`endif
        end
        6'd1: rdata[CNT_W-1:0] = period_sh_q;
        6'd2: rdata[DT_W-1:0]  = deadtime_q;
        6'd3: rdata[0]         = wrap_q;
        6'd4: rdata[3:0]       = h_tgt_q;
        default: begin
          for (int i = 0; i < NCH; i++)
            if (duty_hit && duty_idx == 6'(i)) rdata[CNT_W-1:0] = duty_sh_q[i];
        end
      endcase
    end
  end

  // Register writes, shadow transfer, shared counter, PWM compare, wrap status
  always_comb begin
    en_d         = en_q;
    irq_en_d     = irq_en_q;
    period_sh_d  = period_sh_q;
    period_act_d = period_act_q;
    deadtime_d   = deadtime_q;
    duty_sh_d    = duty_sh_q;
    duty_act_d   = duty_act_q;
    cnt_d        = cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
    center_d     = center_q;
    center_act_d = center_act_q;
    down_d       = down_q;
    wrap_now = en_q && (period_act_q != '0) &&
               (center_act_q ? (down_q && cnt_q == '0) : (cnt_q == period_act_q - ONE));
`else
    wrap_now = en_q && (period_act_q != '0) && (cnt_q == period_act_q - ONE);
`endif
    load = wrap_now || !en_q;

    for (int i = 0; i < NCH; i++)
      pwm_d[i] = en_q && (period_act_q != '0) && (cnt_q < duty_act_q[i]);

`ifdef PWM_CENTER_ALIGN_EN
    if (!en_q || period_act_q == '0) begin
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (wrap_now) begin
      // A new center-aligned period starts rising from 1 so that 0 is seen once per period
      cnt_d  = (center_q && period_sh_q != '0) ? ONE : '0;
      down_d = 1'b0;
    end else if (center_act_q) begin
      if (down_q) begin
        cnt_d = cnt_q - ONE;
      end else if (cnt_q >= period_act_q) begin
        cnt_d  = cnt_q - ONE;
        down_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q + ONE;
    end
    if (load) center_act_d = center_q;
`else
    if (!en_q || period_act_q == '0) cnt_d = '0;
    else if (wrap_now)               cnt_d = '0;
    else                             cnt_d = cnt_q + ONE;
`endif

    if (load) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end

    // A wrap in the same cycle as a clear keeps the flag set
    wrap_d = wrap_now || (wrap_q && !(wr_en && word == 6'd3 && apb.PWDATA[0]));

    if (wr_en) begin
      case (word)
        6'd0: begin
          en_d     = apb.PWDATA[0];
          irq_en_d = apb.PWDATA[1];
`ifdef PWM_CENTER_ALIGN_EN
          center_d = apb.PWDATA[2];
`endif
        end
        6'd1: period_sh_d = apb.PWDATA[CNT_W-1:0];
        6'd2: deadtime_d  = apb.PWDATA[DT_W-1:0];
        default: begin
          for (int i = 0; i < NCH; i++)
            if (duty_hit && duty_idx == 6'(i)) duty_sh_d[i] = apb.PWDATA[CNT_W-1:0];
        end
      endcase
    end
  end

  // H-bridge next state: any new target passes through an all-off dead window
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    h_act_d = h_act_q;
    h_tgt_d = h_tgt_q;
    dt_load = (deadtime_q == '0) ? DT_ONE : deadtime_q;
    case (state_q)
      ST_IDLE: begin
        if (hb_wr && apb.PWDATA[3:0] != h_act_q) begin
          h_tgt_d = apb.PWDATA[3:0];
          dt_d    = dt_load;
          state_d = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (hb_wr) begin
          h_tgt_d = apb.PWDATA[3:0];
          dt_d    = dt_load;
        end else if (dt_q == DT_ONE) begin
          h_act_d = h_tgt_q;
          state_d = ST_IDLE;
        end else begin
          dt_d = dt_q - DT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    h_in_d = (state_d == ST_IDLE) ? h_act_d : 4'b0000;
  end

  // Register file, counter and PWM outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q         <= 1'b0;
      irq_en_q     <= 1'b0;
      period_sh_q  <= DEF_P;
      period_act_q <= DEF_P;
      deadtime_q   <= '0;
      wrap_q       <= 1'b0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_sh_q[i]  <= DEF_D;
        duty_act_q[i] <= DEF_D;
      end
`ifdef PWM_CENTER_ALIGN_EN
      center_q     <= 1'b0;
      center_act_q <= 1'b0;
      down_q       <= 1'b0;
`endif
    end else begin
      en_q         <= en_d;
      irq_en_q     <= irq_en_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      deadtime_q   <= deadtime_d;
      wrap_q       <= wrap_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
`ifdef PWM_CENTER_ALIGN_EN
      center_q     <= center_d;
      center_act_q <= center_act_d;
      down_q       <= down_d;
`endif
    end
  end

  // H-bridge state register and registered gate outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      dt_q    <= '0;
      h_act_q <= 4'b0000;
      h_tgt_q <= 4'b0000;
      h_in_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      h_act_q <= h_act_d;
      h_tgt_q <= h_tgt_d;
      h_in_q  <= h_in_d;
    end
  end

endmodule

// File: tb/tb_apb_pwm_multi.sv
// Self-checking bench for apb_pwm_multi: directed scenarios plus randomized
// APB traffic, checked every cycle against a behavioural model.
module tb_apb_pwm_multi;
  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           fabint;
  logic [NCH-1:0] pwm;
  logic [3:0]     h_in;

  apb_pwm_multi_if bus();

  apb_pwm_multi #(
    .NCH(NCH), .CNT_W(16), .DEFAULT_PERIOD(40000), .DEFAULT_DUTY(20000), .DT_W(8)
  ) dut (
    .PCLK(clk), .PRESET(rst), .apb(bus.slave),
    .FABINT(fabint), .PWM(pwm), .H_IN(h_in)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             m_cnt, m_pact, m_psh, m_dt, m_dead;
  int             m_dsh [NCH];
  int             m_dact [NCH];
  bit             m_en, m_irq, m_wrap;
  logic [NCH-1:0] m_pwm;
  logic [3:0]     m_hact, m_htgt;

  task automatic model_step();
    bit wr, wrap_now, clr, legal;
    int w, d;
    if (rst) begin
      m_en = 0; m_irq = 0; m_wrap = 0; m_cnt = 0; m_pwm = '0;
      m_psh = 40000; m_pact = 40000; m_dt = 0; m_dead = 0;
      m_hact = 4'h0; m_htgt = 4'h0;
      for (int i = 0; i < NCH; i++) begin m_dsh[i] = 20000; m_dact[i] = 20000; end
      return;
    end
    wr = bus.PSEL && bus.PENABLE && bus.PWRITE;
    w  = int'(bus.PADDR[7:2]);
    d  = int'(bus.PWDATA[15:0]);
    // PWM output for the current counter position, then advance the position
    wrap_now = m_en && m_pact != 0 && m_cnt == m_pact - 1;
    for (int i = 0; i < NCH; i++) m_pwm[i] = m_en && m_pact != 0 && m_cnt < m_dact[i];
    m_cnt = (!m_en || m_pact == 0) ? 0 : (m_cnt + 1) % m_pact;
    if (wrap_now || !m_en) begin
      m_pact = m_psh;
      for (int i = 0; i < NCH; i++) m_dact[i] = m_dsh[i];
    end
    // H-bridge: m_dead = number of all-off cycles still to come
    legal = !((bus.PWDATA[1] && bus.PWDATA[0]) || (bus.PWDATA[3] && bus.PWDATA[2]));
    if (wr && w == 4 && legal && (m_dead > 0 || bus.PWDATA[3:0] != m_hact)) begin
      m_htgt = bus.PWDATA[3:0];
      m_dead = (m_dt == 0) ? 1 : m_dt;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) m_hact = m_htgt;
    end
    clr    = wr && w == 3 && bus.PWDATA[0];
    m_wrap = wrap_now || (m_wrap && !clr);
    if (wr) begin
      if (w == 0) begin m_en = bus.PWDATA[0]; m_irq = bus.PWDATA[1]; end
      else if (w == 1) m_psh = d;
      else if (w == 2) m_dt = int'(bus.PWDATA[7:0]);
      else if (w >= 8 && w < 8 + NCH) m_dsh[w-8] = d;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    int w = int'(a[7:2]);
    if (w == 0) return {30'b0, m_irq, m_en};
    if (w == 1) return 32'(m_psh);
    if (w == 2) return 32'(m_dt);
    if (w == 3) return {31'b0, m_wrap};
    if (w == 4) return {28'b0, m_htgt};
    if (w >= 8 && w < 8 + NCH) return 32'(m_dsh[w-8]);
    return 32'h0;
  endfunction

  function automatic logic exp_err();
    int   w      = int'(bus.PADDR[7:2]);
    logic mapped = (w <= 4) || (w >= 8 && w < 8 + NCH);
    logic ill    = (bus.PWDATA[1] & bus.PWDATA[0]) | (bus.PWDATA[3] & bus.PWDATA[2]);
    return bus.PSEL && bus.PENABLE && (!mapped || (bus.PWRITE && w == 4 && ill));
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Cycle-by-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    chk("pwm",     32'(pwm),         32'(m_pwm));
    chk("h_in",    32'(h_in),        32'(m_dead > 0 ? 4'h0 : m_hact));
    chk("fabint",  32'(fabint),      32'(m_irq & m_wrap));
    chk("pslverr", 32'(bus.PSLVERR), 32'(exp_err()));
    chk("pready",  32'(bus.PREADY),  32'h1);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus tasks ----------------
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    err = bus.PSLVERR;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input bit use_model, input logic [31:0] exp_c);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    chk($sformatf("rd_%02h", a), bus.PRDATA, use_model ? model_rd(a) : exp_c);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic count_high(input int n, input int ch, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm[ch]) c++;
    end
  endtask

  task automatic wait_cnt(input int target, input int limit);
    int g = 0;
    while (m_cnt != target && g < limit) begin
      @(posedge clk); #1;
      g++;
    end
    chk("wait_cnt", 32'(m_cnt), 32'(target));
  endtask

  task automatic count_dead(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (h_in != 4'h0) break;
      n++;
    end
  endtask

  logic [7:0] unmapped [6] = '{8'h14, 8'h18, 8'h1C, 8'h28, 8'h40, 8'hFC};

  initial begin
    logic        err;
    int          c;
    logic [7:0]  a;
    logic [31:0] d;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h0; bus.PWDATA = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm",    32'(pwm),    32'h0);
    chk("rst_h_in",   32'(h_in),   32'h0);
    chk("rst_fabint", 32'(fabint), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset register values
    apb_read(8'h00, 0, 32'h0);
    apb_read(8'h04, 0, 32'd40000);
    apb_read(8'h08, 0, 32'h0);
    apb_read(8'h0C, 0, 32'h0);
    apb_read(8'h20, 0, 32'd20000);
    apb_read(8'h24, 0, 32'd20000);

    // Default 500 Hz waveform: 20000 high in every 40000-cycle window
    apb_write(8'h00, 32'h1, err);
    count_high(40000, 0, c);
    chk("dflt_high", 32'(c), 32'd20000);

    // Mid-period duty update with PERIOD=100
    apb_write(8'h00, 32'h0, err);
    apb_write(8'h04, 32'd100, err);
    apb_write(8'h00, 32'h1, err);
    wait_cnt(30, 200);
    apb_write(8'h20, 32'd10, err);
    repeat (200) @(posedge clk);
    count_high(100, 0, c);
    chk("duty10_high", 32'(c), 32'd10);
    apb_write(8'h20, 32'd0, err);
    repeat (200) @(posedge clk);
    count_high(100, 0, c);
    chk("duty0_high", 32'(c), 32'd0);
    apb_write(8'h20, 32'd150, err);
    repeat (200) @(posedge clk);
    count_high(100, 0, c);
    chk("duty150_high", 32'(c), 32'd100);
    count_high(100, 1, c);
    chk("ch1_full_high", 32'(c), 32'd100);

    // PERIOD=0: output low, no wraps
    apb_write(8'h04, 32'd0, err);
    repeat (200) @(posedge clk);
    apb_write(8'h0C, 32'h1, err);
    repeat (50) @(posedge clk);
    count_high(100, 0, c);
    chk("p0_high", 32'(c), 32'd0);
    apb_read(8'h0C, 0, 32'h0);

    // Wrap interrupt with PERIOD=50
    apb_write(8'h00, 32'h0, err);
    apb_write(8'h04, 32'd50, err);
    apb_write(8'h0C, 32'h1, err);
    apb_write(8'h00, 32'h3, err);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fabint) break;
    end
    chk("irq_rise", 32'(fabint), 32'h1);
    apb_write(8'h0C, 32'h1, err);
    @(negedge clk);
    chk("irq_w1c", 32'(fabint), 32'h0);
    wait_cnt(47, 100);
    apb_write(8'h0C, 32'h1, err);
    @(negedge clk);
    chk("irq_w1c_on_wrap", 32'(fabint), 32'h1);

    // H-bridge dead time
    apb_write(8'h08, 32'd5, err);
    apb_write(8'h10, 32'h5, err);
    repeat (10) @(posedge clk);
    apb_write(8'h10, 32'h6, err);
    count_dead(c);
    chk("hb_dead5", 32'(c), 32'd5);
    chk("hb_val6", 32'(h_in), 32'h6);
    apb_write(8'h10, 32'h3, err);
    chk("hb_illegal_err", 32'(err), 32'h1);
    repeat (3) @(negedge clk);
    chk("hb_illegal_hold", 32'(h_in), 32'h6);
    apb_read(8'h10, 0, 32'h6);
    apb_write(8'h08, 32'd4, err);
    apb_write(8'h10, 32'h9, err);
    apb_write(8'h10, 32'h5, err);
    count_dead(c);
    chk("hb_restart4", 32'(c), 32'd4);
    chk("hb_val5", 32'(h_in), 32'h5);

    // Asynchronous reset in the middle of a dead window
    apb_write(8'h10, 32'hA, err);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_h_in",   32'(h_in),   32'h0);
    chk("arst_pwm",    32'(pwm),    32'h0);
    chk("arst_fabint", 32'(fabint), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst_idle_h_in", 32'(h_in), 32'h0);
    apb_read(8'h08, 0, 32'h0);
    apb_read(8'h04, 0, 32'd40000);

    // Randomized register traffic
    for (int op = 0; op < 250; op++) begin
      case ($urandom_range(0, 9))
        0:       begin a = 8'h00; d = 32'($urandom_range(0, 7));  end
        1:       begin a = 8'h04; d = 32'($urandom_range(0, 24)); end
        2:       begin a = 8'h08; d = 32'($urandom_range(0, 6));  end
        3:       begin a = 8'h0C; d = 32'($urandom_range(0, 1));  end
        4, 5:    begin a = 8'h10; d = 32'($urandom_range(0, 15)); end
        6:       begin a = 8'h20; d = 32'($urandom_range(0, 28)); end
        7:       begin a = 8'h24; d = 32'($urandom_range(0, 28)); end
        default: begin a = unmapped[$urandom_range(0, 5)]; d = $urandom; end
      endcase
      a = a | 8'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) apb_write(a, d, err);
      else                          apb_read(a, 1, 32'h0);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
